// File: rtl/uart_rx.sv
// 8N1 UART receive stage: 2-flop synchroniser, oversampled bit recovery and
// CPU-facing data/status flags (full, framing error, overrun).
module uart_rx #(
  parameter int OVS = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rx,
  input  logic [7:0] bauddiv,
  input  logic       rdack,
  output logic [7:0] rxdata,
  output logic       rxfull,
  output logic       ferr,
  output logic       oerr,
  output logic       busy
);

  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] HALF_TICK = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(OVS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic [1:0]    sync_reg, sync_next;
  logic          rxs;
  logic [2:0]    state_reg, state_next;
  logic [7:0]    presc_reg, presc_next;
  logic [CW-1:0] tick_cnt_reg, tick_cnt_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          done_reg, done_next;
  logic          stop_bit_reg, stop_bit_next;
  logic [7:0]    rxdata_reg, rxdata_next;
  logic          rxfull_reg, rxfull_next;
  logic          ferr_reg, ferr_next;
  logic          oerr_reg, oerr_next;
  logic          tick;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = rx;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  assign rxs  = sync_reg[1];
  assign tick = (state_reg != S_IDLE) && (presc_reg == bauddiv);

  always_comb begin
    state_next    = state_reg;
    presc_next    = (state_reg == S_IDLE || tick) ? 8'd0 : presc_reg + 8'd1;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    done_next     = 1'b0;
    stop_bit_next = stop_bit_reg;
    case (state_reg)
      S_IDLE: begin
        tick_cnt_next = '0;
        if (!rxs) state_next = S_START;
      end
      S_START: if (tick) begin
        if (tick_cnt_reg == HALF_TICK) begin
          tick_cnt_next = '0;
          bit_cnt_next  = 3'd0;
          state_next    = rxs ? S_IDLE : S_DATA;
        end else begin
          tick_cnt_next = tick_cnt_reg + 1'b1;
        end
      end
      S_DATA: if (tick) begin
        if (tick_cnt_reg == LAST_TICK) begin
          tick_cnt_next = '0;
          shift_next    = {rxs, shift_reg[7:1]};
          bit_cnt_next  = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) state_next = S_STOP;
        end else begin
          tick_cnt_next = tick_cnt_reg + 1'b1;
        end
      end
      S_STOP: if (tick) begin
        if (tick_cnt_reg == LAST_TICK) begin
          tick_cnt_next = '0;
          done_next     = 1'b1;
          stop_bit_next = rxs;
          state_next    = rxs ? S_IDLE : S_BREAK;
        end else begin
          tick_cnt_next = tick_cnt_reg + 1'b1;
        end
      end
      // Line held low past the stop bit: wait for it to go high before re-arming
      S_BREAK: if (rxs) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // A read in the completion cycle frees the register, so the new byte is taken
  always_comb begin
    rxdata_next = rxdata_reg;
    rxfull_next = rxfull_reg;
    ferr_next   = ferr_reg;
    oerr_next   = oerr_reg;
    if (done_reg) begin
      if (!rxfull_reg || rdack) begin
        rxdata_next = shift_reg;
        rxfull_next = 1'b1;
        ferr_next   = !stop_bit_reg;
        oerr_next   = 1'b0;
      end else begin
        oerr_next = 1'b1;
      end
    end else if (rdack) begin
      rxfull_next = 1'b0;
      ferr_next   = 1'b0;
      oerr_next   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_reg     <= 2'b11;
      state_reg    <= S_IDLE;
      presc_reg    <= 8'd0;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= 3'd0;
      shift_reg    <= 8'd0;
      done_reg     <= 1'b0;
      stop_bit_reg <= 1'b1;
      rxdata_reg   <= 8'd0;
      rxfull_reg   <= 1'b0;
      ferr_reg     <= 1'b0;
      oerr_reg     <= 1'b0;
    end else begin
      sync_reg     <= sync_next;
      state_reg    <= state_next;
      presc_reg    <= presc_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      done_reg     <= done_next;
      stop_bit_reg <= stop_bit_next;
      rxdata_reg   <= rxdata_next;
      rxfull_reg   <= rxfull_next;
      ferr_reg     <= ferr_next;
      oerr_reg     <= oerr_next;
    end
  end

  assign rxdata = rxdata_reg;
  assign rxfull = rxfull_reg;
  assign ferr   = ferr_reg;
  assign oerr   = oerr_reg;
  assign busy   = (state_reg != S_IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive stage of the UART. Sits directly upstream of the data register and the status register.
- Deserialises 8N1 frames from RX using a 16x oversample tick derived from the baud divisor value.
- Presents the received byte, a full flag and error flags to the CPU-side registers.
- Interrupt logic consumes RXFULL, FERR and OERR.

Parameters:
- OVS, 16, oversample ticks per bit period (must be a power of 2, at least 8)

Ports:
- CLK  input  1  system clock, all state updates on the rising edge
- NRST  input  1  asynchronous active-low reset
- RX  input  1  serial line, idle high, asynchronous to CLK
- BAUDDIV  input  8  divisor D; one oversample tick every D+1 CLK cycles
- RDACK  input  1  single-cycle pulse when the CPU reads the data register
- RXDATA  output  8  last accepted byte
- RXFULL  output  1  unread byte present in RXDATA
- FERR  output  1  framing error: stop bit sampled low
- OERR  output  1  overrun: a frame completed while RXFULL=1
- BUSY  output  1  frame reception in progress (state is not IDLE)

Behaviour:
- Reset (NRST=0, asynchronous): RXDATA=0x00, RXFULL=0, FERR=0, OERR=0, BUSY=0. State=IDLE, prescaler=0, tick counter=0, bit counter=0, synchroniser flops=1.
- A reset asserted mid-frame discards the partial frame. After release, the block waits for a fresh falling edge.
- Synchroniser: RX passes through 2 flops to give rxs. All decisions use rxs, so edges are seen 2 cycles late.
- Prescaler: counts 0..D and emits tick when count==D, then wraps to 0.
  - D=0 gives a tick every cycle.
  - BAUDDIV is sampled live. Changing it mid-frame is undefined; the bench must not do it.
- In IDLE, the prescaler and tick counter are held at 0.
- State machine (the tick counter counts ticks within the current state):
  - IDLE: on rxs=0, go to START with counters cleared. BUSY=1 from the next cycle.
  - START: on the tick where the counter reaches OVS/2-1 (mid start bit), sample rxs.
    - rxs=1: false start, return to IDLE with no flag changes.
    - rxs=0: go to DATA, bit counter=0, tick counter=0.
  - DATA: every OVS ticks, sample rxs into the shift register LSB first and increment the bit counter. After the 8th sample, go to STOP.
  - STOP: after OVS ticks, sample rxs. This is the completion event.
    - rxs=1: go to IDLE.
    - rxs=0: go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. No new frame starts until the line is high.
- Completion event, registered on the cycle after the stop-bit sample tick:
  - If RXFULL=0, or RDACK=1 in that same cycle: RXDATA <= shift register, RXFULL stays/becomes 1, FERR <= (stop bit==0), OERR <= 0.
  - If RXFULL=1 and RDACK=0: RXDATA is unchanged (the old byte is kept), OERR <= 1, FERR is unchanged, and the new byte is dropped.
- RDACK with no completion in the same cycle clears RXFULL, FERR and OERR on the next edge.
- RDACK while RXFULL=0 is harmless and clears any stale flags.
- Frame timing at D=0, OVS=16:
  - Start-bit sample at cycle 2+8 after the falling edge.
  - Data bit k sampled at 10+16(k+1).
  - Stop bit sampled at 154.
  - RXFULL rises at cycle 155 relative to the RX falling edge (±1).

Test Plan:
- Reset then idle RX=1 for 500 cycles, D=0 -> all outputs 0, BUSY never asserts.
- D=0, send frame 0xA5 (bits LSB first) with stop=1 -> RXFULL=1 about 155 cycles after the start edge, RXDATA=0xA5, FERR=0, OERR=0; RDACK pulse -> RXFULL=0 next cycle.
- D=3 (tick every 4 cycles), send 0x3C then 0xFF back-to-back with no RDACK -> first byte latched as 0x3C; at the second completion OERR=1, RXDATA still 0x3C; RDACK clears RXFULL and OERR.
- D=0, send 0x55 with stop bit 0, RX held low a further 40 cycles then high -> RXDATA=0x55, RXFULL=1, FERR=1; BUSY stays 1 until RX returns high; a following frame 0x12 after RDACK is received correctly with FERR=0.
- D=0, 4-cycle low glitch on RX -> start-bit sample sees 1, return to IDLE, no flag changes, BUSY drops within 12 cycles.
- Assert NRST mid-frame (after bit 3 of 0x81), release, send 0x81 again -> no partial byte delivered; the second frame gives RXDATA=0x81. Also drive RDACK coincident with a completion while RXFULL=1 -> new byte loaded, RXFULL=1, OERR=0.
